// File: rtl/sdram_ahb_pkg.sv
// Shared types and defaults for the SDRAM AHB-side arbiter and its watchdog.
package sdram_ahb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/sdram_ahb_watchdog.sv
// Saturating cycle counter that flags a bus transfer which has waited TIMEOUT cycles.
module sdram_ahb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // A zero TIMEOUT still needs a legal one-bit counter; expiry is then masked off.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (count_reg == LIMIT);

endmodule

// File: rtl/sdram_ahb_arbiter.sv
// Round-robin arbiter for two single-word requesters in front of the SDRAM controller's
// AHB-style slave port, with a watchdog and a mandatory idle gap between transfers.
module sdram_ahb_arbiter
    import sdram_ahb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              HSEL,
    output logic              HWRITE,
    output logic [ADDR_W-1:0] HADDR,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic [DATA_W-1:0] HRDATA,
    output logic              busy,
    output logic              grant_id
);

    state_t            state_reg;
    logic              last_grant_reg;
    logic              owner_reg;
    logic              hsel_reg;
    logic              hwrite_reg;
    logic [ADDR_W-1:0] haddr_reg;
    logic [DATA_W-1:0] hwdata_reg;
    logic              busy_reg;
    logic [1:0]        ack_reg;
    logic [1:0]        err_reg;
    logic [DATA_W-1:0] rdata_reg [2];

    logic [1:0]        req_vec;
    logic              pick;
    logic              wd_expired;

    assign req_vec = {m1_req, m0_req};
    // On a tie the requester that did not win last time goes next.
    assign pick    = (req_vec == 2'b11) ? ~last_grant_reg : req_vec[1];

    sdram_ahb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (HCLK),
        .srst    (HRESET),
        .clear   (state_reg != ISSUE),
        .enable  (state_reg == ISSUE),
        .expired (wd_expired)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg      <= IDLE;
            last_grant_reg <= REQ_M1;
            owner_reg      <= REQ_M0;
            hsel_reg       <= 1'b0;
            hwrite_reg     <= 1'b0;
            haddr_reg      <= '0;
            hwdata_reg     <= '0;
            busy_reg       <= 1'b0;
            ack_reg        <= '0;
            err_reg        <= '0;
            rdata_reg[0]   <= '0;
            rdata_reg[1]   <= '0;
        end else begin
            ack_reg <= '0;
            err_reg <= '0;
            unique case (state_reg)
                IDLE: begin
                    if (|req_vec) begin
                        state_reg      <= ISSUE;
                        hsel_reg       <= 1'b1;
                        busy_reg       <= 1'b1;
                        owner_reg      <= pick;
                        last_grant_reg <= pick;
                        hwrite_reg     <= pick ? m1_write : m0_write;
                        haddr_reg      <= pick ? m1_addr  : m0_addr;
                        hwdata_reg     <= pick ? m1_wdata : m0_wdata;
                    end
                end
                ISSUE: begin
                    // HREADY takes priority over a watchdog expiry on the same edge.
                    if (HREADY || wd_expired) begin
                        state_reg  <= GAP;
                        hsel_reg   <= 1'b0;
                        hwrite_reg <= 1'b0;
                        haddr_reg  <= '0;
                        hwdata_reg <= '0;
                        if (HREADY) begin
                            ack_reg[owner_reg] <= 1'b1;
                            if (!hwrite_reg) begin
                                rdata_reg[owner_reg] <= HRDATA;
                            end
                        end else begin
                            err_reg[owner_reg] <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign HSEL     = hsel_reg;
    assign HWRITE   = hwrite_reg;
    assign HADDR    = haddr_reg;
    assign HWDATA   = hwdata_reg;
    assign busy     = busy_reg;
    assign grant_id = owner_reg;
    assign m0_ack   = ack_reg[REQ_M0];
    assign m1_ack   = ack_reg[REQ_M1];
    assign m0_err   = err_reg[REQ_M0];
    assign m1_err   = err_reg[REQ_M1];
    assign m0_rdata = rdata_reg[REQ_M0];
    assign m1_rdata = rdata_reg[REQ_M1];

endmodule
